junction_controller: RTL and testbench
======================================

Name: junction_controller

Overview:
- Sequencer for a two-approach road junction with a pedestrian crossing.
- Time-shares the junction between approach A, approach B and a pedestrian phase, and drives two traffic-light sets plus a walk lamp.
- Light encoding per set is red/amber/green, using the codebase sequence red -> red+amber -> green -> amber -> red.
- Sits above the traffic-light datapath as its scheduler; `button` is the pedestrian request input.

Parameters:
- RED_AMBER_CYC, 2, cycles in red+amber before green (1..256)
- GREEN_CYC, 8, maximum cycles of green per approach (1..256)
- AMBER_CYC, 2, cycles of amber after green (1..256)
- ALL_RED_CYC, 1, all-red clearance cycles after each amber (1..256)
- PED_CYC, 6, cycles of pedestrian walk phase (1..256)
- MIN_GREEN, 4, minimum green cycles when green is cut short (only used with the optional feature; 1..GREEN_CYC)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- button  in  1  pedestrian request, level-sampled every cycle
- red_a  out  1  approach A red lamp
- amber_a  out  1  approach A amber lamp
- green_a  out  1  approach A green lamp
- red_b  out  1  approach B red lamp
- amber_b  out  1  approach B amber lamp
- green_b  out  1  approach B green lamp
- walk  out  1  pedestrian walk lamp
- ped_pending  out  1  registered pedestrian request awaiting service
- phase  out  4  current state code (debug/verification)

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- While rst=1 at an edge:
  - state <- ALL_RED_B; timer <- ALL_RED_CYC-1; ped_pending <- 0.
  - Outputs: red_a=red_b=1; all amber, green and walk=0; phase=7.
- Applies mid-operation too: any state is abandoned at the next edge; no amber run-out.
- States and phase codes (lamps in each state):
  - A_RA 0: red_a + amber_a; red_b.
  - A_G 1: green_a; red_b.
  - A_AM 2: amber_a; red_b.
  - ALL_RED_A 3: red_a; red_b.
  - B_RA 4, B_G 5, B_AM 6, ALL_RED_B 7: mirror of 0-3 with A and B swapped.
  - PED_WALK 8: red_a; red_b; walk.
  - Codes 9-15 are illegal; recover to ALL_RED_B at the next edge.
- Lamp outputs are a pure decode of the state register (no extra latency); exactly one lamp combination per state as listed.
- Timer (8-bit):
  - Loaded with DURATION-1 on entry to each state.
  - Decrements each cycle.
  - The state advances at the edge where timer==0, so each state lasts exactly its parameter count of cycles.
- Transitions on expiry:
  - A_RA -> A_G -> A_AM -> ALL_RED_A.
  - ALL_RED_A -> PED_WALK if ped_pending=1, else B_RA.
  - B_RA -> B_G -> B_AM -> ALL_RED_B.
  - ALL_RED_B -> PED_WALK if ped_pending=1, else A_RA.
  - PED_WALK -> the approach that did not precede it: after A -> B_RA, after B -> A_RA. A 1-bit `next_side` register tracks this.
- ped_pending:
  - Set at any edge where button=1 and the state is not PED_WALK.
  - Cleared at the edge that enters PED_WALK. That clear takes priority over a simultaneous button=1.
  - button during PED_WALK is ignored.
  - The all-red exit decision uses the registered ped_pending only: a button first seen at the exit edge is served at the next all-red.
- Green is never skipped. The pedestrian phase only ever follows an all-red.
- Safety invariant: never green_a/amber_a together with green_b/amber_b; walk=1 only when red_a=red_b=1.

Optional Feature:
- Macro: GREEN_CUT_EN.
- Defined:
  - While in A_G/B_G with ped_pending=1, green ends at the edge after it has been active MIN_GREEN cycles (or on normal expiry if sooner).
  - Exit goes to amber as usual.
  - If pending arrives after MIN_GREEN has already elapsed, green ends at the next edge.
- Undefined: green always lasts GREEN_CYC; MIN_GREEN is unused.

Test Plan:
- Cycle timing, defaults:
  - Stimulus: release rst, count edges from release; button=0.
  - Required: A_RA at edges 1-2, A_G 3-10, A_AM 11-12, ALL_RED_A 13, B_RA 14-15, B_G 16-23, B_AM 24-25, ALL_RED_B 26, A_RA 27.
- Pedestrian request:
  - Stimulus: 1-cycle button at edge 5.
  - Required: ped_pending=1 after edge 5; PED_WALK (walk=1, both red) edges 14-19; ped_pending=0 from edge 14; B_RA 20-21; B_G 22-29.
- Button ignored during walk:
  - Stimulus: button held at 1 through PED_WALK.
  - Required: ped_pending stays 0 in walk; then sets at the first non-walk edge and is served at the following all-red.
- Reset mid-operation:
  - Stimulus: rst=1 for one edge during B_G.
  - Required: next cycle phase=7, red_a=red_b=1, ped_pending=0; A_RA follows one cycle after release.
- GREEN_CUT_EN:
  - Stimulus: button at edge 3.
  - Required: A_G edges 3-6 only; A_AM 7-8; ALL_RED_A 9; PED_WALK 10-15.
- Safety check over 1000 random-button cycles:
  - Required: conflict invariant never violated; phase never in 9-15.

Source files
------------

// File: rtl/junction_controller.sv
// junction_controller
//
// Scheduler for a two-approach road junction with a pedestrian crossing.
// The junction is time-shared between approach A, approach B and a
// pedestrian walk phase. Each approach steps through
// red -> red+amber -> green -> amber -> red, and an all-red clearance
// follows every amber. The walk phase is only ever entered from an
// all-red and hands the junction to the approach that did not precede it.
//
// Optional feature (macro GREEN_CUT_EN): while a pedestrian request is
// pending, green is cut short after MIN_GREEN cycles. Without the macro,
// green always lasts GREEN_CYC cycles and MIN_GREEN has no effect.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   button       pedestrian request, level-sampled every cycle
//   red_a/amber_a/green_a   approach A lamps
//   red_b/amber_b/green_b   approach B lamps
//   walk         pedestrian walk lamp
//   ped_pending  registered pedestrian request awaiting service
//   phase        current state code (0..8)

module junction_controller #(
  parameter int RED_AMBER_CYC = 2,
  parameter int GREEN_CYC     = 8,
  parameter int AMBER_CYC     = 2,
  parameter int ALL_RED_CYC   = 1,
  parameter int PED_CYC       = 6,
  parameter int MIN_GREEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  output logic       red_a,
  output logic       amber_a,
  output logic       green_a,
  output logic       red_b,
  output logic       amber_b,
  output logic       green_b,
  output logic       walk,
  output logic       ped_pending,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    A_RA      = 4'd0,
    A_G       = 4'd1,
    A_AM      = 4'd2,
    ALL_RED_A = 4'd3,
    B_RA      = 4'd4,
    B_G       = 4'd5,
    B_AM      = 4'd6,
    ALL_RED_B = 4'd7,
    PED_WALK  = 4'd8
  } state_t;

  // Timer reload values: each state lasts exactly its duration in cycles.
  localparam logic [7:0] RA_LOAD  = 8'(RED_AMBER_CYC - 1);
  localparam logic [7:0] G_LOAD   = 8'(GREEN_CYC - 1);
  localparam logic [7:0] AM_LOAD  = 8'(AMBER_CYC - 1);
  localparam logic [7:0] AR_LOAD  = 8'(ALL_RED_CYC - 1);
  localparam logic [7:0] PED_LOAD = 8'(PED_CYC - 1);

  // Green has been lit MIN_GREEN cycles once the timer has fallen to this.
  localparam logic [7:0] CUT_AT = 8'(GREEN_CYC - MIN_GREEN);

`ifdef GREEN_CUT_EN
  localparam logic CUT_EN = 1'b1;
`else
  localparam logic CUT_EN = 1'b0;
`endif

  state_t     state_r;
  logic [7:0] timer_r;
  logic       ped_pending_r;
  logic       next_side_r;   // 1: walk phase hands over to B, 0: to A

  state_t     next_state_s;
  logic       illegal_s;
  logic       green_cut_s;
  logic       advance_s;
  logic       enter_walk_s;

  function automatic logic [7:0] load_for(input state_t s);
    logic [7:0] v;
    case (s)
      A_RA, B_RA:           v = RA_LOAD;
      A_G, B_G:             v = G_LOAD;
      A_AM, B_AM:           v = AM_LOAD;
      ALL_RED_A, ALL_RED_B: v = AR_LOAD;
      PED_WALK:             v = PED_LOAD;
      default:              v = AR_LOAD;
    endcase
    return v;
  endfunction

  // Successor of the current state, taken only when the state advances.
  always_comb begin
    next_state_s = ALL_RED_B;
    illegal_s    = 1'b0;
    case (state_r)
      A_RA:      next_state_s = A_G;
      A_G:       next_state_s = A_AM;
      A_AM:      next_state_s = ALL_RED_A;
      ALL_RED_A: next_state_s = ped_pending_r ? PED_WALK : B_RA;
      B_RA:      next_state_s = B_G;
      B_G:       next_state_s = B_AM;
      B_AM:      next_state_s = ALL_RED_B;
      ALL_RED_B: next_state_s = ped_pending_r ? PED_WALK : A_RA;
      PED_WALK:  next_state_s = next_side_r ? B_RA : A_RA;
      default: begin
        next_state_s = ALL_RED_B;
        illegal_s    = 1'b1;
      end
    endcase
  end

  // Advance on timer expiry, on a pedestrian green cut, or out of a bad code.
  always_comb begin
    if (CUT_EN && ped_pending_r && ((state_r == A_G) || (state_r == B_G))
        && (timer_r <= CUT_AT)) begin
      green_cut_s = 1'b1;
    end else begin
      green_cut_s = 1'b0;
    end
    advance_s    = (timer_r == 8'd0) || green_cut_s || illegal_s;
    enter_walk_s = advance_s && (next_state_s == PED_WALK);
  end

  // State, timer, pending request and walk hand-over side.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ALL_RED_B;
      timer_r       <= AR_LOAD;
      ped_pending_r <= 1'b0;
      next_side_r   <= 1'b0;
    end else begin
      if (advance_s) begin
        state_r <= next_state_s;
        timer_r <= load_for(next_state_s);
      end else begin
        timer_r <= timer_r - 8'd1;
      end

      // Entering the walk clears the request even if button is held.
      if (enter_walk_s) begin
        ped_pending_r <= 1'b0;
        next_side_r   <= (state_r == ALL_RED_A);
      end else if (button && (state_r != PED_WALK)) begin
        ped_pending_r <= 1'b1;
      end else begin
        ped_pending_r <= ped_pending_r;
      end
    end
  end

  // Lamp decode straight from the state register: no added latency.
  always_comb begin
    red_a   = 1'b1;
    amber_a = 1'b0;
    green_a = 1'b0;
    red_b   = 1'b1;
    amber_b = 1'b0;
    green_b = 1'b0;
    walk    = 1'b0;
    case (state_r)
      A_RA:      amber_a = 1'b1;
      A_G: begin
        red_a   = 1'b0;
        green_a = 1'b1;
      end
      A_AM: begin
        red_a   = 1'b0;
        amber_a = 1'b1;
      end
      ALL_RED_A: red_a = 1'b1;
      B_RA:      amber_b = 1'b1;
      B_G: begin
        red_b   = 1'b0;
        green_b = 1'b1;
      end
      B_AM: begin
        red_b   = 1'b0;
        amber_b = 1'b1;
      end
      ALL_RED_B: red_b = 1'b1;
      PED_WALK:  walk = 1'b1;
      default:   red_a = 1'b1;
    endcase
  end

  assign ped_pending = ped_pending_r;
  assign phase       = state_r;

endmodule

// File: tb/tb_junction_controller.sv
// Self-checking bench for junction_controller with default parameters.
// Edges are counted from reset release; outputs are sampled on the falling
// edge following each counted rising edge.

module tb_junction_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       red_a, amber_a, green_a, red_b, amber_b, green_b, walk;
  logic       ped_pending;
  logic [3:0] phase;

  int checks = 0;
  int errors = 0;

  junction_controller dut (
    .clk(clk), .rst(rst), .button(button),
    .red_a(red_a), .amber_a(amber_a), .green_a(green_a),
    .red_b(red_b), .amber_b(amber_b), .green_b(green_b),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  // Expected lamps {red_a,amber_a,green_a,red_b,amber_b,green_b,walk} per state.
  function automatic logic [6:0] lamp_model(input logic [3:0] p);
    logic [6:0] v;
    case (p)
      4'd0:    v = 7'b110_100_0;
      4'd1:    v = 7'b001_100_0;
      4'd2:    v = 7'b010_100_0;
      4'd3:    v = 7'b100_100_0;
      4'd4:    v = 7'b100_110_0;
      4'd5:    v = 7'b100_001_0;
      4'd6:    v = 7'b100_010_0;
      4'd7:    v = 7'b100_100_0;
      4'd8:    v = 7'b100_100_1;
      default: v = 7'b000_000_0;
    endcase
    return v;
  endfunction

  // Phase after edge e with no pedestrian traffic.
  function automatic logic [3:0] timing_exp(input int e);
    if (e <= 2)       return 4'd0;
    else if (e <= 10) return 4'd1;
    else if (e <= 12) return 4'd2;
    else if (e == 13) return 4'd3;
    else if (e <= 15) return 4'd4;
    else if (e <= 23) return 4'd5;
    else if (e <= 25) return 4'd6;
    else if (e == 26) return 4'd7;
    else              return 4'd0;
  endfunction

  // Phase after edge e with a request registered during the first A green
  // (uncut), and a second request registered during B_RA.
  function automatic logic [3:0] ped_exp(input int e);
    if (e <= 2)       return 4'd0;
    else if (e <= 10) return 4'd1;
    else if (e <= 12) return 4'd2;
    else if (e == 13) return 4'd3;
    else if (e <= 19) return 4'd8;
    else if (e <= 21) return 4'd4;
    else if (e <= 29) return 4'd5;
    else if (e <= 31) return 4'd6;
    else if (e == 32) return 4'd7;
    else if (e <= 38) return 4'd8;
    else              return 4'd0;
  endfunction

  function automatic logic [6:0] lamps_now();
    return {red_a, amber_a, green_a, red_b, amber_b, green_b, walk};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    button = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (phase !== 4'd7) begin
      errors++;
      $display("FAIL reset_phase: got %0d expected 7", phase);
    end
    checks++;
    if (lamps_now() !== 7'b100_100_0) begin
      errors++;
      $display("FAIL reset_lamps: got %b expected 1001000", lamps_now());
    end
    checks++;
    if (ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending: got %b expected 0", ped_pending);
    end
  endtask

  task automatic test_timing();
    logic [3:0] exp_p;
    apply_reset();
    for (int e = 1; e <= 27; e++) begin
      tick();
      exp_p = timing_exp(e);
      checks++;
      if (phase !== exp_p || lamps_now() !== lamp_model(exp_p) || ped_pending !== 1'b0) begin
        errors++;
        $display("FAIL timing edge %0d: phase %0d lamps %b pend %b expected phase %0d lamps %b pend 0",
                 e, phase, lamps_now(), ped_pending, exp_p, lamp_model(exp_p));
      end
    end
  endtask

  task automatic test_ped_request();
    logic [3:0] exp_p;
    logic       exp_pend;
    apply_reset();
    for (int e = 1; e <= 29; e++) begin
      button = (e == 5) ? 1'b1 : 1'b0;
      tick();
      exp_p    = ped_exp(e);
      exp_pend = (e >= 5 && e <= 13) ? 1'b1 : 1'b0;
      checks++;
      if (phase !== exp_p || lamps_now() !== lamp_model(exp_p) || ped_pending !== exp_pend) begin
        errors++;
        $display("FAIL ped_request edge %0d: phase %0d lamps %b pend %b expected phase %0d lamps %b pend %b",
                 e, phase, lamps_now(), ped_pending, exp_p, lamp_model(exp_p), exp_pend);
      end
    end
    button = 1'b0;
  endtask

  task automatic test_walk_ignore();
    logic [3:0] exp_p;
    logic       exp_pend;
    apply_reset();
    for (int e = 1; e <= 40; e++) begin
      // Pulse at 5, then held across the whole walk and one edge beyond.
      button = (e == 5 || (e >= 14 && e <= 21)) ? 1'b1 : 1'b0;
      tick();
      exp_p = ped_exp(e);
      if (e >= 5 && e <= 13)       exp_pend = 1'b1;
      else if (e >= 21 && e <= 32) exp_pend = 1'b1;
      else                         exp_pend = 1'b0;
      checks++;
      if (phase !== exp_p || lamps_now() !== lamp_model(exp_p) || ped_pending !== exp_pend) begin
        errors++;
        $display("FAIL walk_ignore edge %0d: phase %0d lamps %b pend %b expected phase %0d lamps %b pend %b",
                 e, phase, lamps_now(), ped_pending, exp_p, lamp_model(exp_p), exp_pend);
      end
    end
    button = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int e = 1; e <= 18; e++) begin
      button = (e == 15) ? 1'b1 : 1'b0;
      tick();
    end
    button = 1'b0;
    checks++;
    if (phase !== 4'd5 || ped_pending !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: phase %0d pend %b expected phase 5 pend 1", phase, ped_pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (phase !== 4'd7 || lamps_now() !== 7'b100_100_0 || ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: phase %0d lamps %b pend %b expected phase 7 lamps 1001000 pend 0",
               phase, lamps_now(), ped_pending);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (phase !== timing_exp(e)) begin
        errors++;
        $display("FAIL reset_mid_release edge %0d: phase %0d expected %0d", e, phase, timing_exp(e));
      end
    end
  endtask

  task automatic test_green_cut();
    logic [3:0] exp_p;
    apply_reset();
    for (int e = 1; e <= 19; e++) begin
      button = (e == 3) ? 1'b1 : 1'b0;
      tick();
`ifdef GREEN_CUT_EN
      if (e <= 2)       exp_p = 4'd0;
      else if (e <= 6)  exp_p = 4'd1;
      else if (e <= 8)  exp_p = 4'd2;
      else if (e == 9)  exp_p = 4'd3;
      else if (e <= 15) exp_p = 4'd8;
      else              exp_p = 4'd4;
`else
      if (e <= 2)       exp_p = 4'd0;
      else if (e <= 10) exp_p = 4'd1;
      else if (e <= 12) exp_p = 4'd2;
      else if (e == 13) exp_p = 4'd3;
      else              exp_p = 4'd8;
`endif
      checks++;
      if (phase !== exp_p || lamps_now() !== lamp_model(exp_p)) begin
        errors++;
        $display("FAIL green_cut edge %0d: phase %0d lamps %b expected phase %0d lamps %b",
                 e, phase, lamps_now(), exp_p, lamp_model(exp_p));
      end
    end
    button = 1'b0;
  endtask

  task automatic test_safety_random();
    int walks = 0;
    apply_reset();
    for (int c = 0; c < 1000; c++) begin
      button = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      tick();
      if (walk === 1'b1) walks++;
      checks++;
      if ((((green_a | amber_a) & (green_b | amber_b)) !== 1'b0)
          || ((walk & ~(red_a & red_b)) !== 1'b0)
          || (phase > 4'd8)
          || (lamps_now() !== lamp_model(phase))) begin
        errors++;
        $display("FAIL safety cycle %0d: phase %0d lamps %b", c, phase, lamps_now());
      end
    end
    button = 1'b0;
    checks++;
    if (walks == 0) begin
      errors++;
      $display("FAIL safety_walk_seen: got %0d walk cycles expected more than 0", walks);
    end
  endtask

  initial begin
    rst    = 1'b1;
    button = 1'b0;
    test_reset();
    test_timing();
`ifndef GREEN_CUT_EN
    test_ped_request();
    test_walk_ignore();
`endif
    test_reset_mid();
    test_green_cut();
    test_safety_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
